serializer_10b: RTL and testbench
=================================

SERIALIZER_10B -- requirements
Module: serializer_10b

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the transmitted-data-symbol counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port enable_i, input, 1: link transmit enable.
REQ-005 The block SHALL have port symbol_i, input, 10: 10b symbol, bit 0 = a, bits 5:0 = 6b sub-block, bits 9:6 = 4b sub-block.
REQ-006 The block SHALL have port symbol_valid_i, input, 1: symbol_i is valid.
REQ-007 The block SHALL have port symbol_ready_o, output, 1: block accepts symbol_i this cycle.
REQ-008 The block SHALL have port serial_o, output, 1: serial line bit.
REQ-009 The block SHALL have port sym_start_o, output, 1: serial_o carries bit 0 of a symbol.
REQ-010 The block SHALL have port fill_o, output, 1: current symbol on serial_o is an inserted comma.
REQ-011 The block SHALL have port sym_cnt_o, output, CNT_W: count of data symbols started on the line.

Function
REQ-012 The block SHALL implement states OFF and RUN.
REQ-013 OFF->RUN SHALL occur on a clock edge with enable_i=1; on that edge: shift register loaded with next comma, bit_cnt=0.
REQ-014 RUN->OFF SHALL occur on any clock edge with enable_i=0, including mid-symbol; on that edge: holding register emptied, bit_cnt=0, shift register cleared, current symbol abandoned.
REQ-015 In OFF: serial_o=0, sym_start_o=0, fill_o=0, symbol_ready_o=0.
REQ-016 The block SHALL hold a one-entry holding register; symbol_ready_o = (state==RUN) and holding register empty; transfer when symbol_valid_i and symbol_ready_o are both high.
REQ-017 symbol_valid_i while symbol_ready_o=0 SHALL be ignored; no requirement on upstream to hold data, no loss once accepted (except REQ-014).
REQ-018 In RUN, serial_o SHALL equal shift register bit 0; shift right one bit per clock, 10 bits per symbol, bit a first, bit j last.
REQ-019 bit_cnt SHALL count 0..9 in RUN and wrap 9->0; sym_start_o = RUN and bit_cnt==0.
REQ-020 On the edge with bit_cnt==9: shift register loads the holding register contents if full (holding register emptied), else the next comma.
REQ-021 A symbol accepted on the bit_cnt==9 edge SHALL NOT bypass; it is held and sent in the following symbol slot.
REQ-022 Comma fill SHALL alternate K28.5 RD- = 10'h17C and RD+ = 10'h283, starting at 10'h17C after reset; polarity toggles on each inserted comma and is NOT reset by RUN->OFF.
REQ-023 fill_o SHALL be high for all 10 bit-cycles of an inserted comma, low for data symbols.
REQ-024 sym_cnt_o SHALL increment by 1 on each load of a data symbol into the shift register, wrapping modulo 2^CNT_W, unaffected by enable_i.
REQ-025 Latency: a symbol accepted while bit_cnt=k (k<9) SHALL appear on serial_o starting 9-k+1 cycles later; a symbol accepted at k=9 starts 11 cycles later.
REQ-026 Sustained throughput SHALL be one symbol per 10 cycles with no fill when the upstream supplies a symbol at least once per slot.

Reset
REQ-027 Asserting reset SHALL immediately force: state OFF, holding register empty, shift register 0, bit_cnt 0, comma polarity RD-, sym_cnt_o 0.
REQ-028 During reset: serial_o=0, sym_start_o=0, fill_o=0, symbol_ready_o=0.
REQ-029 Reset asserted mid-symbol SHALL abandon the symbol; after deassertion, the block remains OFF until enable_i is sampled high.

Verification
REQ-030 Reset, enable_i=1, no valid -> line bits 0,0,1,1,1,1,1,0,1,0 then 1,1,0,0,0,0,0,1,0,1, repeating; fill_o=1; sym_start_o every 10th cycle; sym_cnt_o=0.
REQ-031 Continuous valid with 10'h2AA, 10'h155 supplied each slot -> no commas after the first slot, serial alternates per bit for both symbols, sym_cnt_o counts 1,2,...
REQ-032 Single symbol 10'h3F0 accepted at bit_cnt=3 -> first bit on line 7 cycles later, bits 0,0,0,0,1,1,1,1,1,1; symbol_ready_o low from acceptance until the bit_cnt==9 load.
REQ-033 Symbol accepted exactly at bit_cnt=9 -> next slot is a comma, data follows in the slot after.
REQ-034 enable_i dropped at bit_cnt=4 with holding register full -> serial_o=0 next cycle, held symbol discarded, sym_cnt_o unchanged; re-enable -> comma with next polarity in sequence.
REQ-035 reset pulse mid-data-symbol with CNT_W=4 after 17 symbols (sym_cnt_o=1) -> all outputs 0; re-enable -> first comma 10'h17C.

Source files
------------

// File: rtl/serializer_10b.sv
// 10b symbol serializer: one-entry holding register feeding a 10-bit shift register,
// with K28.5 comma fill of alternating disparity whenever no data symbol is waiting.
module serializer_10b #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [9:0]       symbol_i,
  input  logic             symbol_valid_i,
  output logic             symbol_ready_o,
  output logic             serial_o,
  output logic             sym_start_o,
  output logic             fill_o,
  output logic [CNT_W-1:0] sym_cnt_o
);

  typedef enum logic {OFF, RUN} state_t;

  localparam logic [9:0] COMMA_NEG = 10'h17C;
  localparam logic [9:0] COMMA_POS = 10'h283;

  state_t           r_state;
  state_t           w_next_state;
  logic [9:0]       r_shift;
  logic [9:0]       r_hold_data;
  logic             r_hold_full;
  logic [3:0]       r_bit_cnt;
  logic             r_fill;
  logic             r_rd_pos;
  logic [CNT_W-1:0] r_sym_cnt;

  logic [9:0]       w_comma;
  logic             w_accept;
  logic             w_slot_end;

  assign w_comma    = r_rd_pos ? COMMA_POS : COMMA_NEG;
  assign w_accept   = symbol_valid_i && symbol_ready_o;
  assign w_slot_end = (r_bit_cnt == 4'd9);
  assign sym_cnt_o  = r_sym_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= OFF;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      OFF:     if (enable_i)  w_next_state = RUN;
      RUN:     if (!enable_i) w_next_state = OFF;
      default: w_next_state = OFF;
    endcase
  end

  always_comb begin
    symbol_ready_o = 1'b0;
    serial_o       = 1'b0;
    sym_start_o    = 1'b0;
    fill_o         = 1'b0;
    if (r_state == RUN) begin
      symbol_ready_o = !r_hold_full;
      serial_o       = r_shift[0];
      sym_start_o    = (r_bit_cnt == 4'd0);
      fill_o         = r_fill;
    end
  end

  // Dropping enable abandons the symbol in flight and anything held; the comma
  // polarity deliberately survives so the disparity sequence continues on re-enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
      r_fill      <= 1'b0;
      r_rd_pos    <= 1'b0;
      r_sym_cnt   <= '0;
    end else begin
      case (r_state)
        OFF: begin
          if (enable_i) begin
            r_shift   <= w_comma;
            r_fill    <= 1'b1;
            r_rd_pos  <= ~r_rd_pos;
            r_bit_cnt <= '0;
          end
        end
        RUN: begin
          if (!enable_i) begin
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_fill      <= 1'b0;
          end else begin
            if (w_slot_end) begin
              r_bit_cnt <= '0;
              if (r_hold_full) begin
                r_shift     <= r_hold_data;
                r_hold_full <= 1'b0;
                r_fill      <= 1'b0;
                r_sym_cnt   <= r_sym_cnt + 1'b1;
              end else begin
                r_shift  <= w_comma;
                r_fill   <= 1'b1;
                r_rd_pos <= ~r_rd_pos;
              end
            end else begin
              r_shift   <= {1'b0, r_shift[9:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            // Acceptance only happens with the holding register empty, so a symbol
            // taken on the slot-end edge waits for the following slot.
            if (w_accept) begin
              r_hold_data <= symbol_i;
              r_hold_full <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_10b.sv
// Scoreboard bench for serializer_10b: a slot-level reference model predicts every
// line cycle, a separate monitor pops and compares each sampled cycle.
module tb_serializer_10b;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable_i = 1'b0;
  logic [9:0]       symbol_i = '0;
  logic             symbol_valid_i = 1'b0;
  logic             symbol_ready_o;
  logic             serial_o;
  logic             sym_start_o;
  logic             fill_o;
  logic [CNT_W-1:0] sym_cnt_o;

  serializer_10b #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable_i),
    .symbol_i       (symbol_i),
    .symbol_valid_i (symbol_valid_i),
    .symbol_ready_o (symbol_ready_o),
    .serial_o       (serial_o),
    .sym_start_o    (sym_start_o),
    .fill_o         (fill_o),
    .sym_cnt_o      (sym_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ser;
    logic       st;
    logic       fill;
    logic       rdy;
    logic [3:0] cnt;
  } obs_t;

  obs_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  bit   tbActive = 1'b0;

  // Reference model: which word occupies the current slot, position within it,
  // symbols waiting, next comma polarity and the data-symbol count.
  bit         mRun = 1'b0;
  int         mPos = 0;
  logic [9:0] mWord = '0;
  bit         mFill = 1'b0;
  bit         mPol = 1'b0;
  int         mCnt = 0;
  int         mLoads = 0;
  logic [9:0] mPend[$];

  function automatic logic [9:0] nextComma();
    return mPol ? 10'h283 : 10'h17C;
  endfunction

  task automatic modelEdge(input bit en, input bit v, input logic [9:0] d,
                           input bit rst, output bit acc);
    acc = 1'b0;
    if (rst) begin
      mRun = 1'b0; mPos = 0; mPol = 1'b0; mCnt = 0; mLoads = 0; mFill = 1'b0;
      mPend.delete();
    end else if (!mRun) begin
      if (en) begin
        mRun = 1'b1; mPos = 0; mWord = nextComma(); mFill = 1'b1; mPol = !mPol;
      end
    end else if (!en) begin
      mRun = 1'b0; mPos = 0; mFill = 1'b0;
      mPend.delete();
    end else begin
      acc = v && (mPend.size() == 0);
      if (mPos == 9) begin
        mPos = 0;
        if (mPend.size() > 0) begin
          mWord = mPend.pop_front(); mFill = 1'b0;
          mCnt = (mCnt + 1) % (1 << CNT_W); mLoads++;
        end else begin
          mWord = nextComma(); mFill = 1'b1; mPol = !mPol;
        end
      end else begin
        mPos++;
      end
      if (acc) mPend.push_back(d);
    end
  endtask

  function automatic obs_t expectNow();
    obs_t e;
    e = '0;
    e.cnt = mCnt[3:0];
    if (mRun) begin
      e.ser  = mWord[mPos];
      e.st   = (mPos == 0);
      e.fill = mFill;
      e.rdy  = (mPend.size() == 0);
    end
    return e;
  endfunction

  function automatic obs_t sampleDut();
    return obs_t'({serial_o, sym_start_o, fill_o, symbol_ready_o, sym_cnt_o});
  endfunction

  task automatic checkOutput(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s @%0t: got ser=%0b start=%0b fill=%0b rdy=%0b cnt=%0d, expected ser=%0b start=%0b fill=%0b rdy=%0b cnt=%0d",
                  name, $time, got.ser, got.st, got.fill, got.rdy, got.cnt,
                  exp.ser, exp.st, exp.fill, exp.rdy, exp.cnt);
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    $display("[TB] FAIL %s: wait bound expired (got timeout, expected condition reached)", name);
  endtask

  task automatic applyStimulus(input bit en, input bit v, input logic [9:0] d,
                               input bit rst, output bit acc);
    @(negedge clk);
    enable_i       = en;
    symbol_valid_i = v;
    symbol_i       = d;
    reset          = rst;
    if (rst) begin
      #1;
      checkOutput("resetAsync", sampleDut(), obs_t'(0));
    end
    modelEdge(en, v, d, rst, acc);
    expQ.push_back(expectNow());
    tbActive = 1'b1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 10'h0, 1'b0, a);
  endtask

  task automatic waitSlot(input int pos, input string name);
    bit a;
    int guard;
    guard = 0;
    while (!(mRun && mPos == pos && mPend.size() == 0) && guard < 40) begin
      applyStimulus(1'b1, 1'b0, 10'h0, 1'b0, a);
      guard++;
    end
    if (guard >= 40) timeoutFail(name);
  endtask

  // Monitor: one predicted line state per cycle, compared just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tbActive) begin
        if (expQ.size() == 0) timeoutFail("scoreboardEmpty");
        else checkOutput("line", sampleDut(), expQ.pop_front());
      end
    end
  end

  initial begin
    bit         a;
    bit         alt;
    int         guard;
    logic [9:0] d;

    // Reset, then enable-low cycles: block must stay silent.
    applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, a);
    applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, a);
    applyStimulus(1'b0, 1'b1, 10'h155, 1'b0, a);
    applyStimulus(1'b0, 1'b0, 10'h0, 1'b0, a);

    // Comma fill only.
    idle(40);

    // Back-to-back alternating data symbols.
    alt = 1'b0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 1'b1, alt ? 10'h155 : 10'h2AA, 1'b0, a);
      if (a) alt = !alt;
    end
    idle(25);

    // Single symbol accepted at slot position 3.
    waitSlot(3, "waitPos3");
    applyStimulus(1'b1, 1'b1, 10'h3F0, 1'b0, a);
    idle(25);

    // Symbol accepted exactly on the slot-end edge.
    waitSlot(9, "waitPos9");
    applyStimulus(1'b1, 1'b1, 10'h0F3, 1'b0, a);
    idle(25);

    // Drop enable at position 4 with the holding register full, then re-enable.
    waitSlot(2, "waitPos2");
    applyStimulus(1'b1, 1'b1, 10'h1E5, 1'b0, a);
    guard = 0;
    while (mPos != 4 && guard < 20) begin
      applyStimulus(1'b1, 1'b0, 10'h0, 1'b0, a);
      guard++;
    end
    if (guard >= 20) timeoutFail("waitPos4");
    applyStimulus(1'b0, 1'b0, 10'h0, 1'b0, a);
    applyStimulus(1'b0, 1'b0, 10'h0, 1'b0, a);
    idle(25);

    // Reset mid data symbol after 17 loads, then re-enable.
    applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, a);
    guard = 0;
    while (!(mLoads == 17 && mRun && !mFill && mPos == 4) && guard < 400) begin
      d = 10'($urandom);
      applyStimulus(1'b1, 1'b1, d, 1'b0, a);
      guard++;
    end
    if (guard >= 400) timeoutFail("wait17Symbols");
    applyStimulus(1'b1, 1'b0, 10'h0, 1'b1, a);
    applyStimulus(1'b0, 1'b0, 10'h0, 1'b0, a);
    applyStimulus(1'b0, 1'b0, 10'h0, 1'b0, a);
    idle(25);

    // Random traffic with occasional enable drops and resets.
    for (int i = 0; i < 3000; i++) begin
      d = 10'($urandom);
      applyStimulus(($urandom_range(0, 29) != 0), ($urandom_range(0, 2) != 0), d,
                    ($urandom_range(0, 199) == 0), a);
    end

    @(posedge clk);
    #3;
    tbActive = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
